// File: rtl/uart_mon_pkg.sv
// Shared types and helpers for the UART frame monitor.
// Parity modes, FSM state encoding and frame-length arithmetic.
package uart_mon_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    localparam logic [2:0] ST_ARM    = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    // Start bit + data bits + optional parity bit + stop bits.
    function automatic int frame_bits(
        input int      data_bits,
        input parity_t parity,
        input int      stop_bits
    );
        return 1 + data_bits + ((parity == PAR_NONE) ? 0 : 1) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_mon_timer.sv
// Bit timing for the UART frame monitor.
// Phase counter, frame bit position and mid-bit sample strobe.
module uart_mon_timer #(
    parameter int BIT_CYCLES = 6,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    output logic [IDX_W-1:0] bit_idx,
    output logic             sample
);

    localparam int PW = $clog2(BIT_CYCLES);
    localparam logic [PW-1:0]    LAST  = PW'(BIT_CYCLES - 1);
    localparam logic [PW-1:0]    HALF  = PW'(BIT_CYCLES / 2);
    localparam logic [PW-1:0]    P_ONE = PW'(1);
    localparam logic [IDX_W-1:0] I_ONE = IDX_W'(1);

    logic [PW-1:0] phase;

    // Start loads phase 1 with the index at all-ones, so the wrap that
    // ends the start bit lands exactly on data bit 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            phase   <= '0;
            bit_idx <= '0;
        end else if (start) begin
            phase   <= P_ONE;
            bit_idx <= '1;
        end else if (phase == LAST) begin
            phase   <= '0;
            bit_idx <= bit_idx + I_ONE;
        end else begin
            phase <= phase + P_ONE;
        end
    end

    assign sample = (phase == HALF);

endmodule

// File: rtl/uart_frame_monitor.sv
// UART receive monitor: rebuilds frames from a serial line and reports
// data, parity/framing errors and a saturating frame count.
module uart_frame_monitor
    import uart_mon_pkg::*;
#(
    parameter int      BIT_CYCLES = 6,
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 busy
);

    if (BIT_CYCLES < 2) begin : g_bad_cycles
        $error("uart_frame_monitor: BIT_CYCLES must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("uart_frame_monitor: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_frame_monitor: STOP_BITS must be 1 or 2");
    end

    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP =
        IDX_W'(frame_bits(DATA_BITS, PARITY, STOP_BITS) - 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic             ODD     = (PARITY == PAR_ODD);

    logic [2:0]           state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 ferr_acc;
    logic                 stop_bad;
    logic [IDX_W-1:0]     bit_idx;
    logic                 sample;
    logic                 tmr_clear;
    logic                 tmr_start;

    // Timer is held at zero while waiting and launched on the falling edge.
    assign tmr_start = (state == ST_IDLE) && !rx;
    assign tmr_clear = (state == ST_ARM) || ((state == ST_IDLE) && rx);
    assign stop_bad  = ferr_acc | ~rx;

    uart_mon_timer #(
        .BIT_CYCLES (BIT_CYCLES),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .start   (tmr_start),
        .bit_idx (bit_idx),
        .sample  (sample)
    );

    assign busy = (state == ST_START) || (state == ST_DATA) ||
                  (state == ST_PARITY) || (state == ST_STOP);

    // Frame FSM plus shift register; outputs only move on frame completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ARM;
            shreg      <= '0;
            par_acc    <= 1'b0;
            ferr_acc   <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_ARM: begin
                    if (rx) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!rx) begin
                        state    <= ST_START;
                        par_acc  <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                end
                ST_START: begin
                    if (sample) state <= rx ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (sample) begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (bit_idx == IDX_W'(i)) shreg[i] <= rx;
                        end
                        if (bit_idx == LAST_DATA) begin
                            state <= (PARITY == PAR_NONE) ? ST_STOP
                                                          : ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample) begin
                        par_acc <= (^shreg) ^ rx ^ ODD;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        if (bit_idx == LAST_STOP) begin
                            valid      <= 1'b1;
                            data       <= shreg;
                            parity_err <= par_acc;
                            frame_err  <= stop_bad;
                            if (frame_cnt != '1) begin
                                frame_cnt <= frame_cnt + CNT_ONE;
                            end
                            state <= stop_bad ? ST_ARM : ST_IDLE;
                        end else begin
                            ferr_acc <= stop_bad;
                        end
                    end
                end
                default: state <= ST_ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_monitor.sv
// Self-checking bench for uart_frame_monitor: an 8N1 instance and a
// 7E1 instance with a 2-bit counter, against a frame-level model.
module tb_uart_frame_monitor;
    import uart_mon_pkg::*;

    localparam int BC = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, valid_b;
    logic       perr_a, perr_b;
    logic       ferr_a, ferr_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       busy_a, busy_b;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cnt;
        int         c;
    } rec_t;

    rec_t qa[$];
    rec_t qb[$];

    uart_frame_monitor u_a (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx_a),
        .data       (data_a),
        .valid      (valid_a),
        .parity_err (perr_a),
        .frame_err  (ferr_a),
        .frame_cnt  (cnt_a),
        .busy       (busy_a)
    );

    uart_frame_monitor #(
        .BIT_CYCLES (BC),
        .DATA_BITS  (7),
        .PARITY     (PAR_EVEN),
        .STOP_BITS  (1),
        .CNT_W      (2)
    ) u_b (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx_b),
        .data       (data_b),
        .valid      (valid_b),
        .parity_err (perr_b),
        .frame_err  (ferr_b),
        .frame_cnt  (cnt_b),
        .busy       (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_a)
            qa.push_back('{d: data_a, pe: perr_a, fe: ferr_a,
                           cnt: int'(cnt_a), c: cyc});
        if (valid_b)
            qb.push_back('{d: {1'b0, data_b}, pe: perr_b, fe: ferr_b,
                           cnt: int'(cnt_b), c: cyc});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    // Frame timing model: falling edge to valid, in clock cycles.
    function automatic int lat(input int nd, input int np, input int ns);
        return BC * (nd + np + ns) + BC / 2 + 1;
    endfunction

    task automatic setrx(input bit w, input logic v);
        if (w) rx_b = v;
        else   rx_a = v;
    endtask

    task automatic tx_bit(input bit w, input logic v);
        setrx(w, v);
        repeat (BC) @(negedge clk);
    endtask

    task automatic idle(input bit w, input int n);
        setrx(w, 1'b1);
        repeat (n) @(negedge clk);
    endtask

    // Serial frame: start, data LSB first, parity (7E1 only), one stop.
    task automatic send(input bit w, input logic [7:0] b,
                        input logic pbit, input logic stopv,
                        output int t0);
        t0 = cyc;
        tx_bit(w, 1'b0);
        for (int i = 0; i < (w ? 7 : 8); i++) tx_bit(w, b[i]);
        if (w) tx_bit(w, pbit);
        tx_bit(w, stopv);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        checks++;
        if ({valid_a, busy_a, perr_a, ferr_a} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags_a: got %b want 0000",
                     {valid_a, busy_a, perr_a, ferr_a});
        end
        checks++;
        if (data_a !== 8'h00 || cnt_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs_a: data %h cnt %h want 0 0",
                     data_a, cnt_a);
        end
        checks++;
        if ({valid_b, busy_b, perr_b, ferr_b} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags_b: got %b want 0000",
                     {valid_b, busy_b, perr_b, ferr_b});
        end
        checks++;
        if (data_b !== 7'h00 || cnt_b !== 2'b00) begin
            errors++;
            $display("FAIL reset_regs_b: data %h cnt %h want 0 0",
                     data_b, cnt_b);
        end
    endtask

    task automatic test_single();
        int t0;
        rec_t r;
        do_reset();
        idle(0, 4);
        send(0, 8'h48, 1'b0, 1'b1, t0);
        idle(0, 4);
        checks++;
        if (qa.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d frames want 1", qa.size());
        end
        if (qa.size() > 0) begin
            r = qa.pop_front();
            checks++;
            if (r.d !== 8'h48 || r.pe !== 1'b0 || r.fe !== 1'b0) begin
                errors++;
                $display("FAIL single_frame: data %h pe %b fe %b want 48 0 0",
                         r.d, r.pe, r.fe);
            end
            checks++;
            if (r.c - t0 != lat(8, 0, 1)) begin
                errors++;
                $display("FAIL single_latency: got %0d want %0d",
                         r.c - t0, lat(8, 0, 1));
            end
        end
        checks++;
        if (cnt_a !== 8'd1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL single_after: cnt %0d busy %b want 1 0",
                     cnt_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [5];
        int t0, tmp;
        rec_t r;
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        do_reset();
        idle(0, 3);
        send(0, msg[0], 1'b0, 1'b1, t0);
        for (int i = 1; i < 5; i++) send(0, msg[i], 1'b0, 1'b1, tmp);
        idle(0, 6);
        checks++;
        if (qa.size() != 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d frames want 5", qa.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (qa.size() > 0) begin
                r = qa.pop_front();
                checks++;
                if (r.d !== msg[i] || r.cnt != i + 1 || r.fe !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_frame%0d: data %h cnt %0d fe %b want %h %0d 0",
                             i, r.d, r.cnt, r.fe, msg[i], i + 1);
                end
                checks++;
                if (r.c != t0 + i * BC * 10 + lat(8, 0, 1)) begin
                    errors++;
                    $display("FAIL b2b_time%0d: got %0d want %0d",
                             i, r.c, t0 + i * BC * 10 + lat(8, 0, 1));
                end
            end
        end
        checks++;
        if (cnt_a !== 8'd5) begin
            errors++;
            $display("FAIL b2b_cnt: got %0d want 5", cnt_a);
        end
    endtask

    task automatic test_parity();
        int t [2];
        logic pb [2];
        rec_t r;
        pb = '{1'b0, 1'b1};
        do_reset();
        idle(1, 3);
        send(1, 8'h41, pb[0], 1'b1, t[0]);
        send(1, 8'h41, pb[1], 1'b1, t[1]);
        idle(1, 6);
        checks++;
        if (qb.size() != 2) begin
            errors++;
            $display("FAIL par_count: got %0d frames want 2", qb.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (qb.size() > 0) begin
                r = qb.pop_front();
                checks++;
                if (r.d !== 8'h41 || r.pe !== 1'(i) || r.fe !== 1'b0) begin
                    errors++;
                    $display("FAIL par_frame%0d: data %h pe %b fe %b want 41 %0d 0",
                             i, r.d, r.pe, r.fe, i);
                end
                checks++;
                if (r.c - t[i] != lat(7, 1, 1)) begin
                    errors++;
                    $display("FAIL par_latency%0d: got %0d want %0d",
                             i, r.c - t[i], lat(7, 1, 1));
                end
            end
        end
    endtask

    task automatic test_frame_err();
        int t0;
        rec_t r;
        do_reset();
        idle(0, 3);
        send(0, 8'h55, 1'b0, 1'b0, t0);
        repeat (100) @(negedge clk);
        checks++;
        if (qa.size() != 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d frames want 1", qa.size());
        end
        if (qa.size() > 0) begin
            r = qa.pop_front();
            checks++;
            if (r.d !== 8'h55 || r.fe !== 1'b1 || r.c - t0 != lat(8, 0, 1)) begin
                errors++;
                $display("FAIL ferr_frame: data %h fe %b lat %0d want 55 1 %0d",
                         r.d, r.fe, r.c - t0, lat(8, 0, 1));
            end
        end
        idle(0, 1);
        send(0, 8'h21, 1'b0, 1'b1, t0);
        idle(0, 4);
        checks++;
        if (qa.size() != 1) begin
            errors++;
            $display("FAIL ferr_rearm_count: got %0d frames want 1", qa.size());
        end
        if (qa.size() > 0) begin
            r = qa.pop_front();
            checks++;
            if (r.d !== 8'h21 || r.fe !== 1'b0 || r.cnt != 2) begin
                errors++;
                $display("FAIL ferr_rearm: data %h fe %b cnt %0d want 21 0 2",
                         r.d, r.fe, r.cnt);
            end
        end
    endtask

    task automatic test_glitch();
        int t0;
        logic [7:0] b;
        rec_t r;
        do_reset();
        idle(0, 3);
        setrx(0, 1'b0);
        repeat (2) @(negedge clk);
        idle(0, 80);
        checks++;
        if (qa.size() != 0 || cnt_a !== 8'd0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL glitch: frames %0d cnt %0d busy %b want 0 0 0",
                     qa.size(), cnt_a, busy_a);
        end
        b = 8'($urandom_range(0, 255));
        send(0, b, 1'b0, 1'b1, t0);
        idle(0, 4);
        checks++;
        if (qa.size() != 1) begin
            errors++;
            $display("FAIL glitch_next_count: got %0d want 1", qa.size());
        end
        if (qa.size() > 0) begin
            r = qa.pop_front();
            checks++;
            if (r.d !== b || r.c - t0 != lat(8, 0, 1)) begin
                errors++;
                $display("FAIL glitch_next: data %h lat %0d want %h %0d",
                         r.d, r.c - t0, b, lat(8, 0, 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        logic [7:0] p;
        rec_t r;
        p = 8'h5C;
        do_reset();
        idle(0, 3);
        send(0, 8'hA7, 1'b0, 1'b1, t0);
        idle(0, 3);
        tx_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) tx_bit(0, p[i]);
        setrx(0, p[4]);
        repeat (3) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL rmid_before: busy %b cnt %0d want 1 1",
                     busy_a, cnt_a);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0 || cnt_a !== 8'd0 || data_a !== 8'h00
            || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL rmid_reset: valid %b cnt %0d data %h busy %b want 0 0 00 0",
                     valid_a, cnt_a, data_a, busy_a);
        end
        reset = 1'b0;
        idle(0, 80);
        checks++;
        if (qa.size() != 1) begin
            errors++;
            $display("FAIL rmid_frames: got %0d want 1", qa.size());
        end
        qa.delete();
        send(0, 8'h21, 1'b0, 1'b1, t0);
        idle(0, 4);
        checks++;
        if (qa.size() != 1) begin
            errors++;
            $display("FAIL rmid_next_count: got %0d want 1", qa.size());
        end
        if (qa.size() > 0) begin
            r = qa.pop_front();
            checks++;
            if (r.d !== 8'h21 || r.cnt != 1 || r.fe !== 1'b0) begin
                errors++;
                $display("FAIL rmid_next: data %h cnt %0d fe %b want 21 1 0",
                         r.d, r.cnt, r.fe);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] eb[$];
        logic       ep[$];
        int         et[$];
        logic [7:0] b;
        logic       pbit;
        int         t0, n;
        rec_t       r;
        do_reset();
        idle(0, 3);
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            send(0, b, 1'b0, 1'b1, t0);
            eb.push_back(b);
            et.push_back(t0);
            idle(0, $urandom_range(0, 4));
        end
        idle(0, 6);
        checks++;
        if (qa.size() != 20) begin
            errors++;
            $display("FAIL rand_a_count: got %0d want 20", qa.size());
        end
        n = 0;
        while (qa.size() > 0 && eb.size() > 0) begin
            r = qa.pop_front();
            b = eb.pop_front();
            t0 = et.pop_front();
            n++;
            checks++;
            if (r.d !== b || r.cnt != n || r.fe !== 1'b0 || r.pe !== 1'b0
                || r.c - t0 != lat(8, 0, 1)) begin
                errors++;
                $display("FAIL rand_a%0d: data %h cnt %0d fe %b pe %b lat %0d want %h %0d 0 0 %0d",
                         n, r.d, r.cnt, r.fe, r.pe, r.c - t0, b, n,
                         lat(8, 0, 1));
            end
        end
        eb.delete();
        et.delete();
        idle(1, 3);
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 127));
            pbit = 1'($urandom_range(0, 1));
            send(1, b, pbit, 1'b1, t0);
            eb.push_back(b);
            ep.push_back(($countones(b) + int'(pbit)) % 2 == 1);
            et.push_back(t0);
            idle(1, $urandom_range(0, 3));
        end
        idle(1, 6);
        checks++;
        if (qb.size() != 8) begin
            errors++;
            $display("FAIL rand_b_count: got %0d want 8", qb.size());
        end
        n = 0;
        while (qb.size() > 0 && eb.size() > 0) begin
            r = qb.pop_front();
            b = eb.pop_front();
            pbit = ep.pop_front();
            t0 = et.pop_front();
            n++;
            checks++;
            if (r.d !== b || r.pe !== pbit || r.fe !== 1'b0
                || r.cnt != ((n < 3) ? n : 3)
                || r.c - t0 != lat(7, 1, 1)) begin
                errors++;
                $display("FAIL rand_b%0d: data %h pe %b fe %b cnt %0d lat %0d want %h %b 0 %0d %0d",
                         n, r.d, r.pe, r.fe, r.cnt, r.c - t0, b, pbit,
                         (n < 3) ? n : 3, lat(7, 1, 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
